// File: rtl/mem_rd_sched_pkg.sv
// Shared constants, state encoding and address helpers for the memory read-port scheduler.
// Address layout: thread-region bits above MEM_ADDR_MSB, word-within-region bits below.
package mem_rd_sched_pkg;

  localparam int MEM_TOTAL_MSB = 10;
  localparam int MEM_ADDR_MSB  = 7;
  localparam int BURST_LEN_MSB = 3;
  localparam int AW            = MEM_TOTAL_MSB + 1;
  localparam int LW            = BURST_LEN_MSB + 1;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  // Only the in-region bits advance; the thread bits are carried through untouched.
  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    logic [MEM_ADDR_MSB:0] lo;
    lo = a[MEM_ADDR_MSB:0] + 1'b1;
    return {a[MEM_TOTAL_MSB:MEM_ADDR_MSB+1], lo};
  endfunction

  function automatic logic at_region_end(input logic [AW-1:0] a);
    return &a[MEM_ADDR_MSB:0];
  endfunction

endpackage

// File: rtl/mem_rd_sched_if.sv
// Requester/memory-port bundle for mem_rd_sched; master = requester side, slave = scheduler.
// Requester i occupies slice i of req_addr/req_len; the CPU is index N_CORES.
interface mem_rd_sched_if #(
  parameter int N_CORES = 3
);
  import mem_rd_sched_pkg::*;

  localparam int N_REQ = N_CORES + 1;

  logic [N_REQ-1:0]    req;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*LW-1:0] req_len;
  logic [N_REQ-1:0]    gnt;
  logic                mem_rd_en;
  logic [AW-1:0]       mem_rd_addr;
  logic [N_REQ-1:0]    dout_valid;
  logic                busy;
  logic                err;

  modport master (
    output req, req_addr, req_len,
    input  gnt, mem_rd_en, mem_rd_addr, dout_valid, busy, err
  );

  modport slave (
    input  req, req_addr, req_len,
    output gnt, mem_rd_en, mem_rd_addr, dout_valid, busy, err
  );

endinterface

// File: rtl/mem_rd_sched_rr_pick.sv
// Combinational round-robin picker: first asserted req at or after start, wrapping.
// Zero latency; onehot is all-zero when no req is asserted.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] start,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx
);

  int j;

  // Scanning from the far end lets the nearest candidate overwrite later ones.
  always_comb begin
    onehot = '0;
    idx    = '0;
    j      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(start) + k) % N;
      if (req[j]) begin
        onehot    = '0;
        onehot[j] = 1'b1;
        idx       = PW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_rd_sched.sv
// Read-port scheduler: round-robin over procb readers, CPU lowest priority; grant/first read 1 cycle after req, dout_valid 1 cycle after each read.
// Bursts of 1..16 words run to completion; MEM_RD_SCHED_STARVE_EN adds a CPU anti-starvation override.
module mem_rd_sched
  import mem_rd_sched_pkg::*;
#(
  parameter int N_CORES      = 3,
  parameter int STARVE_LIMIT = 64
) (
  input logic           CLK,
  input logic           RST,
  mem_rd_sched_if.slave bus
);

  localparam int N_REQ = N_CORES + 1;
  localparam int CPU   = N_CORES;
  localparam int PW    = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int WW    = $clog2(N_REQ);
  localparam logic [PW-1:0] RR_LAST = PW'(N_CORES - 1);

  state_t           state_q, state_d;
  logic [WW-1:0]    win_q, win_d;
  logic [AW-1:0]    addr_q;
  logic [LW-1:0]    cnt_q;
  logic             first_q;
  logic             err_q;
  logic [PW-1:0]    rr_ptr_q;
  logic [N_REQ-1:0] dv_q;
  logic [N_REQ-1:0] gnt;
  logic [N_CORES-1:0] pick_oh;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;
  logic             cpu_sel;
  logic             starve;
  logic             busy;

  rr_pick #(.N(N_CORES), .PW(PW)) u_rr_pick (
    .req    (bus.req[N_CORES-1:0]),
    .start  (rr_ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  assign pick_any = |pick_oh;
  assign cpu_sel  = bus.req[CPU] && (!pick_any || starve);
  assign win_d    = cpu_sel ? WW'(CPU) : WW'(pick_idx);

`ifdef MEM_RD_SCHED_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1) + 1;
  logic [CW-1:0] cpu_wait_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cpu_wait_q <= '0;
    end else if (!bus.req[CPU] || gnt[CPU]) begin
      cpu_wait_q <= '0;
    end else if (!(&cpu_wait_q)) begin
      cpu_wait_q <= cpu_wait_q + 1'b1;
    end
  end

  assign starve = (cpu_wait_q >= CW'(STARVE_LIMIT));
`else
  assign starve = 1'b0;
`endif

  a_starve_limit_pos: assert property (@(posedge CLK) STARVE_LIMIT > 0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q == BURST);
    gnt     = '0;
    case (state_q)
      IDLE: begin
        if (|bus.req) state_d = BURST;
      end
      BURST: begin
        if (cnt_q == '0) state_d = IDLE;
        if (first_q) gnt[win_q] = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      win_q    <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      err_q    <= 1'b0;
      rr_ptr_q <= '0;
      dv_q     <= '0;
    end else begin
      dv_q <= '0;
      if (busy) dv_q[win_q] <= 1'b1;
      if (state_q == IDLE) begin
        if (|bus.req) begin
          win_q   <= win_d;
          addr_q  <= bus.req_addr[win_d*AW +: AW];
          cnt_q   <= bus.req_len[win_d*LW +: LW];
          first_q <= 1'b1;
          // A starvation-forced CPU grant leaves the procb rotation where it was.
          if (!cpu_sel) rr_ptr_q <= (pick_idx == RR_LAST) ? '0 : pick_idx + 1'b1;
        end
      end else begin
        first_q <= 1'b0;
        if (cnt_q != '0) begin
          cnt_q  <= cnt_q - 1'b1;
          addr_q <= addr_inc(addr_q);
          if (at_region_end(addr_q)) err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.gnt         = gnt;
  assign bus.mem_rd_en   = busy;
  assign bus.mem_rd_addr = busy ? addr_q : '0;
  assign bus.dout_valid  = dv_q;
  assign bus.busy        = busy;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_mem_rd_sched.sv
// Directed bench for mem_rd_sched: transaction-level model checked every cycle plus literal expectations per scenario.
module tb_mem_rd_sched;
  localparam int NC  = 3;
  localparam int NR  = NC + 1;
  localparam int AWB = 11;
  localparam int LWB = 4;
  localparam int SL  = 8;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  mem_rd_sched_if #(.N_CORES(NC)) bus();

  mem_rd_sched #(.N_CORES(NC), .STARVE_LIMIT(SL)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: one burst in flight described by winner, base, length and word index.
  bit          m_busy;
  int          m_win, m_base, m_len, m_k, m_rr;
  bit          m_err;
  logic [NR-1:0] m_dv;
  bit          starve;
  int          w;
`ifdef MEM_RD_SCHED_STARVE_EN
  int          m_wait;
`endif

  function automatic logic [AWB-1:0] waddr(input int base, input int k);
    return AWB'((base & 'h700) | ((base + k) & 'hFF));
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_busy = 0; m_win = 0; m_base = 0; m_len = 0; m_k = 0; m_rr = 0;
      m_err = 0; m_dv = '0; starve = 0;
`ifdef MEM_RD_SCHED_STARVE_EN
      m_wait = 0;
`endif
    end else begin
`ifdef MEM_RD_SCHED_STARVE_EN
      starve = (m_wait >= SL);
      if (!bus.req[NC] || (m_busy && m_k == 0 && m_win == NC)) m_wait = 0;
      else if (m_wait < SL) m_wait++;
`else
      starve = 0;
`endif
      m_dv = '0;
      if (m_busy) m_dv[m_win] = 1'b1;
      if (m_busy) begin
        if (m_k == m_len) m_busy = 0;
        else begin
          m_k++;
          if ((m_base & 'hFF) + m_k > 'hFF) m_err = 1;
        end
      end else if (bus.req != '0) begin
        w = -1;
        if (!(starve && bus.req[NC]))
          for (int i = 0; i < NC; i++)
            if (w < 0 && bus.req[(m_rr + i) % NC]) w = (m_rr + i) % NC;
        if (w < 0) w = NC;
        else m_rr = (w + 1) % NC;
        m_busy = 1; m_win = w; m_k = 0;
        m_base = int'(bus.req_addr[w*AWB +: AWB]);
        m_len  = int'(bus.req_len[w*LWB +: LWB]);
      end
    end
  end

  bit            chk_en = 0;
  logic [NR-1:0] exp_gnt;
  int            glog[$];
  logic [AWB-1:0] alog[$];
  int            busy_cnt;
  int            dvcnt[NR];

  always @(posedge CLK) begin
    #1;
    if (chk_en) begin
      exp_gnt = '0;
      if (m_busy && m_k == 0) exp_gnt[m_win] = 1'b1;
      chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
      chk("mem_rd_en", 32'(bus.mem_rd_en), 32'(m_busy));
      chk("mem_rd_addr", 32'(bus.mem_rd_addr), m_busy ? 32'(waddr(m_base, m_k)) : 32'd0);
      chk("dout_valid", 32'(bus.dout_valid), 32'(m_dv));
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("err", 32'(bus.err), 32'(m_err));
      for (int i = 0; i < NR; i++) begin
        if (bus.gnt[i]) glog.push_back(i);
        if (bus.dout_valid[i]) dvcnt[i]++;
      end
      if (bus.mem_rd_en) alog.push_back(bus.mem_rd_addr);
      if (bus.busy) busy_cnt++;
    end
  end

  task automatic clear_logs();
    glog.delete();
    alog.delete();
    busy_cnt = 0;
    for (int i = 0; i < NR; i++) dvcnt[i] = 0;
  endtask

  task automatic set_req(input int i, input int addr, input int len);
    bus.req_addr[i*AWB +: AWB] = AWB'(addr);
    bus.req_len[i*LWB +: LWB]  = LWB'(len);
    bus.req[i] = 1'b1;
  endtask

  task automatic wait_gnt(input int i);
    int n = 0;
    while (n < 40) begin
      @(posedge CLK); #1;
      if (bus.gnt[i]) break;
      n++;
    end
    chk($sformatf("gnt_seen[%0d]", i), 32'(bus.gnt[i]), 32'd1);
    bus.req[i] = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
    chk({tag, "_rd_en"}, 32'(bus.mem_rd_en), 32'd0);
    chk({tag, "_rd_addr"}, 32'(bus.mem_rd_addr), 32'd0);
    chk({tag, "_dout_valid"}, 32'(bus.dout_valid), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    chk_quiet("rst");
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  int cnt0, cnt_cpu;

  initial begin
    bus.req = '0; bus.req_addr = '0; bus.req_len = '0;
    do_reset();
    chk_en = 1;

    // 1: single procb0 burst of 4 words
    clear_logs();
    @(negedge CLK); set_req(0, 'h040, 3);
    wait_gnt(0);
    repeat (6) @(negedge CLK);
    chk("t1_ngnt", glog.size(), 1);
    chk("t1_gnt_idx", glog.size() > 0 ? glog[0] : -1, 0);
    chk("t1_nreads", alog.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t1_addr%0d", i), alog.size() > i ? 32'(alog[i]) : 32'hFFF, 32'h40 + i);
    chk("t1_dv0_cycles", dvcnt[0], 4);
    chk("t1_busy_cycles", busy_cnt, 4);

    // 2: all requesters continuous, single-word bursts
    do_reset();
    clear_logs();
    @(negedge CLK);
    set_req(0, 'h010, 0); set_req(1, 'h020, 0); set_req(2, 'h030, 0); set_req(3, 'h380, 0);
    repeat (9) @(negedge CLK);
    bus.req = '0;
    repeat (4) @(negedge CLK);
    chk("t2_ngnt", glog.size(), 5);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_order%0d", i), glog.size() > i ? glog[i] : -1, i % NC);
    cnt_cpu = 0;
    foreach (glog[i]) if (glog[i] == NC) cnt_cpu++;
    chk("t2_cpu_gnts", cnt_cpu, 0);
    chk("t2_busy_cycles", busy_cnt, 5);

    // 3: CPU alone, 16-word burst
    clear_logs();
    @(negedge CLK); set_req(3, 'h300, 15);
    wait_gnt(3);
    repeat (18) @(negedge CLK);
    chk("t3_ngnt", glog.size(), 1);
    chk("t3_gnt_idx", glog.size() > 0 ? glog[0] : -1, NC);
    chk("t3_busy_cycles", busy_cnt, 16);
    chk("t3_dv3_cycles", dvcnt[3], 16);
    chk("t3_last_addr", alog.size() == 16 ? 32'(alog[15]) : 32'hFFF, 32'h30F);

    // 4: burst across a thread region end
    clear_logs();
    @(negedge CLK); set_req(2, 'h2FF, 1);
    wait_gnt(2);
    repeat (4) @(negedge CLK);
    chk("t4_addr0", alog.size() > 0 ? 32'(alog[0]) : 32'hFFF, 32'h2FF);
    chk("t4_addr1", alog.size() > 1 ? 32'(alog[1]) : 32'hFFF, 32'h200);
    chk("t4_err", 32'(bus.err), 32'd1);
    repeat (5) @(negedge CLK);
    chk("t4_err_sticky", 32'(bus.err), 32'd1);

    // 5: reset in the middle of an 8-word burst
    clear_logs();
    @(negedge CLK); set_req(1, 'h100, 7);
    wait_gnt(1);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("t5_word2_addr", 32'(bus.mem_rd_addr), 32'h102);
    #2;
    RST = 1'b1;
    #1;
    chk_quiet("t5_midrst");
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    clear_logs();
    @(negedge CLK); set_req(0, 'h050, 0); set_req(2, 'h060, 0);
    wait_gnt(0);
    wait_gnt(2);
    repeat (3) @(negedge CLK);
    chk("t5_ngnt", glog.size(), 2);
    chk("t5_first", glog.size() > 0 ? glog[0] : -1, 0);
    chk("t5_second", glog.size() > 1 ? glog[1] : -1, 2);

    // 6: procb0 busy-looping while the CPU waits
    clear_logs();
    @(negedge CLK); set_req(0, 'h070, 0); set_req(3, 'h390, 0);
    repeat (40) @(negedge CLK);
    bus.req = '0;
    repeat (4) @(negedge CLK);
    cnt0 = 0; cnt_cpu = 0;
    foreach (glog[i]) begin
      if (glog[i] == 0) cnt0++;
      if (glog[i] == NC) cnt_cpu++;
    end
    chk("t6_procb0_served", 32'(cnt0 >= 10), 32'd1);
`ifdef MEM_RD_SCHED_STARVE_EN
    chk("t6_cpu_gnt", 32'(cnt_cpu > 0), 32'd1);
`else
    chk("t6_cpu_gnt", cnt_cpu, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
